// File: rtl/sha256_stream_core.sv
// SHA-256 compression engine for the miner datapath.
// Takes one padded 512-bit block per handshake, chains blocks of a message
// through an internal chaining register and emits a digest after the last
// block. UNROLL rounds are evaluated per clock.
module sha256_stream_core #(
   parameter int UNROLL      = 1,
   parameter bit MIDSTATE_EN = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_first,
   input  logic         in_last,
   input  logic         iv_sel,
   input  logic [255:0] iv_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest,
   output logic         busy
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
      $fatal(1, "sha256_stream_core: UNROLL must be 1, 2, 4 or 8");
   end

   localparam logic [255:0] SHA_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [6:0]   STEP   = 7'(UNROLL);
   localparam logic [6:0]   LAST_T = 7'(64 - UNROLL);

   localparam logic [31:0] K_TAB [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_t;

   // Fixed-distance rotates are pure wiring.
   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] small_s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] small_s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   state_t        r_state;
   state_t        w_state_next;
   logic [31:0]   r_w [0:15];
   logic [31:0]   w_ext [0:15+UNROLL];
   logic [255:0]  r_work;
   logic [255:0]  r_chain;
   logic [255:0]  r_digest;
   logic          r_out_valid;
   logic          r_last;
   logic [6:0]    r_t;
   logic [255:0]  w_init;
   logic [255:0]  w_round;
   logic [255:0]  w_sum;

   // State register; reset aborts any block in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = !reset;
            if (in_valid) begin
               w_state_next = ROUND;
            end
         end
         ROUND: begin
            if (r_t == LAST_T) begin
               w_state_next = FINAL;
            end
         end
         FINAL: begin
            w_state_next = r_last ? HOLD : IDLE;
         end
         HOLD: begin
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Initial hash for a new block: external midstate, standard IV, or the chain.
   always_comb begin
      if (in_first && iv_sel && MIDSTATE_EN) begin
         w_init = iv_in;
      end else if (in_first) begin
         w_init = SHA_IV;
      end else begin
         w_init = r_chain;
      end
   end

   // Message schedule: current window plus UNROLL freshly expanded words.
   always_comb begin : p_sched
      for (int i = 0; i < 16; i++) begin
         w_ext[i] = r_w[i];
      end
      for (int i = 0; i < UNROLL; i++) begin
         w_ext[16+i] = small_s1(w_ext[14+i]) + w_ext[9+i] + small_s0(w_ext[1+i]) + w_ext[i];
      end
   end

   // UNROLL chained compression rounds starting at round r_t.
   always_comb begin : p_round
      logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2;
      logic [5:0]  kidx;
      {va, vb, vc, vd, ve, vf, vg, vh} = r_work;
      t1   = '0;
      t2   = '0;
      kidx = '0;
      for (int j = 0; j < UNROLL; j++) begin
         kidx = r_t[5:0] + 6'(j);
         t1 = vh + big_s1(ve) + ((ve & vf) ^ (~ve & vg)) + K_TAB[kidx] + w_ext[j];
         t2 = big_s0(va) + ((va & vb) ^ (va & vc) ^ (vb & vc));
         vh = vg;
         vg = vf;
         vf = ve;
         ve = vd + t1;
         vd = vc;
         vc = vb;
         vb = va;
         va = t1 + t2;
      end
      w_round = {va, vb, vc, vd, ve, vf, vg, vh};
   end

   // Word-wise feed-forward of the chaining value into the working variables.
   for (genvar gi = 0; gi < 8; gi++) begin : g_sum
      assign w_sum[255-32*gi -: 32] = r_chain[255-32*gi -: 32] + r_work[255-32*gi -: 32];
   end

   // Schedule window: load on acceptance, shift by UNROLL words per round cycle.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         if (r_state == IDLE && in_valid) begin
            r_w[i] <= in_block[511-32*i -: 32];
         end else if (r_state == ROUND) begin
            r_w[i] <= w_ext[i+UNROLL];
         end
      end
   end

   // Working variables, chaining register, round counter and digest output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_work      <= '0;
         r_chain     <= SHA_IV;
         r_digest    <= '0;
         r_out_valid <= 1'b0;
         r_last      <= 1'b0;
         r_t         <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_work  <= w_init;
                  r_chain <= w_init;
                  r_last  <= in_last;
                  r_t     <= '0;
               end
            end
            ROUND: begin
               r_work <= w_round;
               r_t    <= r_t + STEP;
            end
            FINAL: begin
               r_chain <= w_sum;
               if (r_last) begin
                  r_digest    <= w_sum;
                  r_out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid  = r_out_valid;
   assign out_digest = r_digest;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: four instances (UNROLL 1/2/4 with midstate,
// UNROLL 1 without) driven in lockstep from a vector table; a scoreboard
// checks every digest and its latency, plus hand sequences for
// backpressure and reset abort.
module tb_sha256_stream_core;
   localparam int NDUT = 4;

   localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] D_448   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] B_M1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] B_M2    = {480'h0, 32'h000001c0};

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef struct packed {
      logic [511:0] blk;
      logic         first;
      logic         last;
      logic         sel;
      logic [255:0] iv;
      logic [255:0] exp_m;   // expected digest with midstate honoured
      logic [255:0] exp_n;   // expected digest with midstate disabled
   } vec_t;

   typedef struct packed {
      logic [255:0] m;
      logic [255:0] n;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst [NDUT];
   logic         in_valid;
   logic [511:0] in_block;
   logic         in_first;
   logic         in_last;
   logic         iv_sel;
   logic [255:0] iv_in;
   logic         out_ready;
   logic         in_ready [NDUT];
   logic         out_valid [NDUT];
   logic [255:0] out_digest [NDUT];
   logic         busy [NDUT];

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   acc_edge [NDUT];
   int   rd_idx [NDUT];
   bit   prev_ov [NDUT];
   exp_t sb_q [$];
   vec_t vecs [11];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      sha256_stream_core #(
         .UNROLL      (gi == 1 ? 2 : (gi == 2 ? 4 : 1)),
         .MIDSTATE_EN (gi == 3 ? 1'b0 : 1'b1)
      ) u_dut (
         .clk        (clk),
         .reset      (rst[gi]),
         .in_valid   (in_valid),
         .in_ready   (in_ready[gi]),
         .in_block   (in_block),
         .in_first   (in_first),
         .in_last    (in_last),
         .iv_sel     (iv_sel),
         .iv_in      (iv_in),
         .out_valid  (out_valid[gi]),
         .out_ready  (out_ready),
         .out_digest (out_digest[gi]),
         .busy       (busy[gi])
      );
   end

   function automatic int du(input int k);
      return (k == 1) ? 2 : ((k == 2) ? 4 : 1);
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Straightforward one-block reference compression.
   function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  v [8];
      logic [31:0]  t1, t2;
      logic [255:0] res;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = v[i] + hin[255-32*i -: 32];
      return res;
   endfunction

   function automatic void chk(input string nm, input int k, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
      end else begin
         $display("ok   %s dut%0d: %h", nm, k, act);
      end
   endfunction

   function automatic bit all_ready();
      bit r = 1'b1;
      for (int k = 0; k < NDUT; k++) r &= in_ready[k];
      return r;
   endfunction

   function automatic bit all_valid();
      bit r = 1'b1;
      for (int k = 0; k < NDUT; k++) r &= out_valid[k];
      return r;
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard monitor: acceptance times, latency on each rising out_valid,
   // digest compare on each output handshake.
   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         if (!rst[k] && in_valid && in_ready[k]) acc_edge[k] = cyc + 1;
         if (out_valid[k] && !prev_ov[k])
            chk("latency", k, 256'(cyc - acc_edge[k]), 256'(64 / du(k) + 1));
         if (out_valid[k] && out_ready) begin
            if (rd_idx[k] < sb_q.size()) begin
               chk("digest", k, out_digest[k], (k == 3) ? sb_q[rd_idx[k]].n : sb_q[rd_idx[k]].m);
               rd_idx[k]++;
            end else begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_digest dut%0d: got %h expected no output", k, out_digest[k]);
            end
         end
         prev_ov[k] = out_valid[k];
      end
   end

   task automatic wait_all_ready();
      for (int n = 0; n < 500; n++) begin
         @(posedge clk); #1;
         if (all_ready()) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready: got timeout expected all in_ready");
   endtask

   task automatic drive(input vec_t v);
      in_valid = 1'b1;
      in_block = v.blk;
      in_first = v.first;
      in_last  = v.last;
      iv_sel   = v.sel;
      iv_in    = v.iv;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input vec_t v, input bit push);
      wait_all_ready();
      if (push && v.last) sb_q.push_back('{m: v.exp_m, n: v.exp_n});
      drive(v);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected summary");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [255:0] mid1, ones, rdig;
      logic [511:0] rb1, rb2;
      vec_t v;
      ones = '1;
      for (int i = 0; i < 16; i++) rb1[511-32*i -: 32] = $urandom;
      for (int i = 0; i < 16; i++) rb2[511-32*i -: 32] = $urandom;
      mid1 = ref_compress(IV, B_M1);
      rdig = ref_compress(IV, rb1);
      //           blk      first last  sel  iv     exp_m                      exp_n
      vecs[0]  = '{B_ABC,   1'b1, 1'b1, 1'b0, '0,   D_ABC,                     D_ABC};
      vecs[1]  = '{B_EMPTY, 1'b1, 1'b1, 1'b0, '0,   D_EMPTY,                   D_EMPTY};
      vecs[2]  = '{B_M1,    1'b1, 1'b0, 1'b0, '0,   '0,                        '0};
      vecs[3]  = '{B_M2,    1'b0, 1'b1, 1'b0, '0,   D_448,                     D_448};
      vecs[4]  = '{B_M1,    1'b1, 1'b0, 1'b0, '0,   '0,                        '0};
      vecs[5]  = '{B_ABC,   1'b1, 1'b1, 1'b0, '0,   D_ABC,                     D_ABC};
      vecs[6]  = '{B_ABC,   1'b1, 1'b1, 1'b1, IV,   D_ABC,                     D_ABC};
      vecs[7]  = '{B_ABC,   1'b1, 1'b1, 1'b1, ones, ref_compress(ones, B_ABC), D_ABC};
      vecs[8]  = '{B_M2,    1'b1, 1'b1, 1'b1, mid1, D_448,                     ref_compress(IV, B_M2)};
      vecs[9]  = '{rb1,     1'b1, 1'b1, 1'b0, '0,   rdig,                      rdig};
      vecs[10] = '{rb2,     1'b0, 1'b1, 1'b0, '0,   ref_compress(rdig, rb2),   ref_compress(rdig, rb2)};

      for (int k = 0; k < NDUT; k++) begin
         rst[k] = 1'b1;
         acc_edge[k] = 0;
         rd_idx[k] = 0;
         prev_ov[k] = 1'b0;
      end
      in_valid = 1'b0; in_block = '0; in_first = 1'b0; in_last = 1'b0;
      iv_sel = 1'b0; iv_in = '0; out_ready = 1'b1;

      // Reset state, then in_ready one cycle after release.
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_in_ready", k, 256'(in_ready[k]), 256'(0));
         chk("rst_out_valid", k, 256'(out_valid[k]), 256'(0));
         chk("rst_out_digest", k, out_digest[k], 256'(0));
         chk("rst_busy", k, 256'(busy[k]), 256'(0));
         rst[k] = 1'b0;
      end
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) chk("post_rst_in_ready", k, 256'(in_ready[k]), 256'(1));

      // Table-driven vectors.
      for (int i = 0; i < 11; i++) send(vecs[i], 1'b1);

      // Backpressure: digest held for 10 cycles, junk in_valid ignored.
      wait_all_ready();
      out_ready = 1'b0;
      send(vecs[0], 1'b1);
      for (int n = 0; n < 200 && !all_valid(); n++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1; in_block = B_EMPTY; in_first = 1'b1; in_last = 1'b1; iv_sel = 1'b0;
      repeat (10) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            chk("hold_valid", k, 256'(out_valid[k]), 256'(1));
            chk("hold_in_ready", k, 256'(in_ready[k]), 256'(0));
            chk("hold_digest", k, out_digest[k], D_ABC);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("release_out_valid", k, 256'(out_valid[k]), 256'(0));
         chk("release_in_ready", k, 256'(in_ready[k]), 256'(1));
      end

      // Reset at round 20 of the second block of a chained message; then
      // a first=0 "abc" must chain from the standard IV again.
      send(vecs[2], 1'b1);
      wait_all_ready();
      v = vecs[3];
      drive(v);
      for (int n = 1; n <= 21; n++) begin
         for (int k = 0; k < NDUT; k++) rst[k] = (n == 20 / du(k) + 1);
         @(posedge clk); #1;
      end
      for (int k = 0; k < NDUT; k++) begin
         rst[k] = 1'b0;
         chk("abort_busy", k, 256'(busy[k]), 256'(0));
         chk("abort_out_valid", k, 256'(out_valid[k]), 256'(0));
      end
      v = '{B_ABC, 1'b0, 1'b1, 1'b0, '0, D_ABC, D_ABC};
      send(v, 1'b1);

      // Drain the scoreboard.
      for (int n = 0; n < 300; n++) begin
         bit done;
         @(posedge clk); #1;
         done = all_ready();
         for (int k = 0; k < NDUT; k++) done &= (rd_idx[k] == sb_q.size());
         if (done) break;
      end
      for (int k = 0; k < NDUT; k++) chk("drain_count", k, 256'(rd_idx[k]), 256'(sb_q.size()));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
